// File: rtl/dqn_pkg.sv
// Shared constants and types for the DQN training datapath stages.
// Used by the output-layer bias-gradient stage and the saturating shifter.
package dqn_pkg;

    localparam int unsigned NUM_OUT = 5;

    localparam logic [3:0] CTRL_NOP    = 4'b0000;
    localparam logic [3:0] CTRL_UPDATE = 4'b0001;

    localparam logic signed [15:0] DELTA_MAX = 16'sh7FFF;
    localparam logic signed [15:0] DELTA_MIN = -16'sh8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        APPLY = 2'd2
    } state_t;

endpackage

// File: rtl/deltab2_gen_if.sv
// Request/result bundle between the training sequencer and the bias-gradient stage.
// master drives the operands and start; slave returns deltas, ctrl and status.
interface deltab2_gen_if;

    logic               start;
    logic [3:0]         step;
    logic [2:0]         action;
    logic signed [31:0] td_target;
    logic signed [31:0] q_1;
    logic signed [31:0] q_2;
    logic signed [31:0] q_3;
    logic signed [31:0] q_4;
    logic signed [31:0] q_5;

    logic [3:0]         ctrl;
    logic signed [15:0] deltab2_1;
    logic signed [15:0] deltab2_2;
    logic signed [15:0] deltab2_3;
    logic signed [15:0] deltab2_4;
    logic signed [15:0] deltab2_5;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, step, action, td_target, q_1, q_2, q_3, q_4, q_5,
        input  ctrl, deltab2_1, deltab2_2, deltab2_3, deltab2_4, deltab2_5,
        input  busy, done, err
    );

    modport slave (
        input  start, step, action, td_target, q_1, q_2, q_3, q_4, q_5,
        output ctrl, deltab2_1, deltab2_2, deltab2_3, deltab2_4, deltab2_5,
        output busy, done, err
    );

endinterface

// File: rtl/dqn_sat_shift.sv
// Arithmetic right shift of a 33-bit signed error term, saturated to 16 bits.
// Shared by the output and hidden-layer delta stages.
module dqn_sat_shift
    import dqn_pkg::*;
(
    input  logic signed [32:0] din,
    input  logic [3:0]         shamt,
    output logic signed [15:0] dout
);

    logic signed [32:0] shifted;
    logic               fits;

    always_comb begin
        shifted = din >>> shamt;
        // In range only when bits 32..15 are all copies of the sign bit.
        fits = (shifted[32:15] == {18{shifted[32]}});
        if (fits) begin
            dout = shifted[15:0];
        end else if (shifted[32]) begin
            dout = DELTA_MIN;
        end else begin
            dout = DELTA_MAX;
        end
    end

endmodule

// File: rtl/deltab2_gen.sv
// Output-layer bias-gradient stage: computes the five bias deltas serially with
// one shared subtractor, then issues a single-cycle update command to the bias bank.
module deltab2_gen #(
    parameter int unsigned LR_SHIFT = 4,
    parameter int unsigned NUM_OUT  = 5
) (
    input logic          clk,
    input logic          rst,
    deltab2_gen_if.slave bus
);

    import dqn_pkg::*;

    localparam logic [3:0] SHAMT      = 4'(LR_SHIFT);
    localparam logic [2:0] LAST_IDX   = 3'(NUM_OUT - 1);
    localparam logic [2:0] MAX_ACTION = 3'(NUM_OUT - 1);

    state_t             state;
    logic [2:0]         idx;
    logic [2:0]         act_r;
    logic signed [31:0] td_r;
    logic signed [31:0] q_r     [NUM_OUT];
    logic signed [15:0] delta_r [NUM_OUT];
    logic [3:0]         ctrl_r;
    logic               busy_r;
    logic               done_r;
    logic               err_r;

    logic signed [31:0] q_in [NUM_OUT];
    logic signed [31:0] q_sel;
    logic signed [32:0] diff;
    logic signed [15:0] delta_sat;
    logic               accept;

    assign q_in[0] = bus.q_1;
    assign q_in[1] = bus.q_2;
    assign q_in[2] = bus.q_3;
    assign q_in[3] = bus.q_4;
    assign q_in[4] = bus.q_5;

    assign accept = (state == IDLE) && bus.start && (bus.step != 4'b0000);

    always_comb begin
        q_sel = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (idx == 3'(i)) begin
                q_sel = q_r[i];
            end
        end
    end

    // Sign-extend both operands so the difference never overflows.
    assign diff = {td_r[31], td_r} - {q_sel[31], q_sel};

    dqn_sat_shift u_sat (
        .din   (diff),
        .shamt (SHAMT),
        .dout  (delta_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            act_r  <= '0;
            td_r   <= '0;
            ctrl_r <= CTRL_NOP;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            for (int unsigned i = 0; i < NUM_OUT; i++) begin
                q_r[i]     <= '0;
                delta_r[i] <= '0;
            end
        end else begin
            ctrl_r <= CTRL_NOP;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        act_r <= bus.action;
                        td_r  <= bus.td_target;
                        for (int unsigned i = 0; i < NUM_OUT; i++) begin
                            q_r[i] <= q_in[i];
                        end
                        if (bus.action <= MAX_ACTION) begin
                            for (int unsigned i = 0; i < NUM_OUT; i++) begin
                                delta_r[i] <= '0;
                            end
                            idx    <= '0;
                            busy_r <= 1'b1;
                            state  <= CALC;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    for (int unsigned i = 0; i < NUM_OUT; i++) begin
                        if (idx == 3'(i)) begin
                            delta_r[i] <= (idx == act_r) ? delta_sat : '0;
                        end
                    end
                    // ctrl/done are registered here so they land exactly in APPLY.
                    if (idx == LAST_IDX) begin
                        idx    <= '0;
                        ctrl_r <= CTRL_UPDATE;
                        done_r <= 1'b1;
                        state  <= APPLY;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                APPLY: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.ctrl      = ctrl_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
    assign bus.deltab2_1 = delta_r[0];
    assign bus.deltab2_2 = delta_r[1];
    assign bus.deltab2_3 = delta_r[2];
    assign bus.deltab2_4 = delta_r[3];
    assign bus.deltab2_5 = delta_r[4];

endmodule

// File: tb/tb_deltab2_gen.sv
// Self-checking bench for deltab2_gen: hand-computed vector table, multi-cycle
// corner sequences, and randomized requests against an arithmetic reference model.
module tb_deltab2_gen;

    localparam int unsigned LR = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    deltab2_gen_if bif();

    deltab2_gen #(.LR_SHIFT(LR), .NUM_OUT(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int total = 0;
    int bad   = 0;

    logic signed [31:0] qv    [5];
    logic signed [15:0] exp_d [5];

    typedef struct {
        logic [3:0]         step;
        logic [2:0]         action;
        logic signed [31:0] td;
        logic signed [31:0] qa;
        logic signed [31:0] qo;
        logic signed [15:0] exp;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // floor((td - q) / 2^LR), clamped to the 16-bit signed range
    function automatic logic signed [15:0] ref_delta(input logic signed [31:0] td,
                                                     input logic signed [31:0] q);
        longint d, r, scale;
        scale = longint'(1) << LR;
        d = longint'(td) - longint'(q);
        if (d >= 0) r = d / scale;
        else        r = -((-d + scale - 1) / scale);
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return 16'(r);
    endfunction

    function automatic logic signed [15:0] out_d(input int k);
        case (k)
            0: return bif.deltab2_1;
            1: return bif.deltab2_2;
            2: return bif.deltab2_3;
            3: return bif.deltab2_4;
            default: return bif.deltab2_5;
        endcase
    endfunction

    function automatic logic signed [31:0] rnd32();
        case ($urandom_range(0, 2))
            0: return 32'(int'($urandom_range(0, 4000)) - 2000);
            1: return 32'(int'($urandom_range(0, 1 << 21)) - (1 << 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic apply_q();
        bif.q_1 = qv[0];
        bif.q_2 = qv[1];
        bif.q_3 = qv[2];
        bif.q_4 = qv[3];
        bif.q_5 = qv[4];
    endtask

    task automatic check_deltas(input string tag);
        for (int k = 0; k < 5; k++)
            check($sformatf("%s d%0d", tag, k + 1), out_d(k), exp_d[k]);
    endtask

    // Issue one request from a negedge and watch cycles 1..8 after the sampling edge.
    task automatic run_op(input logic [3:0] stp, input logic [2:0] act,
                          input logic signed [31:0] td, input int poke, input string tag);
        int kind;
        kind = (stp == 4'd0) ? 0 : (act > 3'd4) ? 1 : 2;
        if (kind == 2)
            for (int k = 0; k < 5; k++)
                exp_d[k] = (k == int'(act)) ? ref_delta(td, qv[k]) : 16'sd0;
        bif.step      = stp;
        bif.action    = act;
        bif.td_target = td;
        apply_q();
        bif.start     = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check($sformatf("%s busy c%0d", tag, c), bif.busy, (kind == 2 && c <= 6) ? 1 : 0);
            check($sformatf("%s ctrl c%0d", tag, c), bif.ctrl, (kind == 2 && c == 6) ? 1 : 0);
            check($sformatf("%s done c%0d", tag, c), bif.done, (kind == 2 && c == 6) ? 1 : 0);
            check($sformatf("%s err c%0d", tag, c), bif.err, (kind == 1 && c == 1) ? 1 : 0);
            if (c == 6 || c == 8) check_deltas($sformatf("%s c%0d", tag, c));
            if (c == 1 || c == poke + 1) bif.start = 1'b0;
            if (c == 2) begin
                bif.action    = 3'($urandom);
                bif.td_target = 32'($urandom);
                for (int k = 0; k < 5; k++) qv[k] = 32'($urandom);
                apply_q();
            end
            if (c == poke) begin
                bif.step  = 4'd1;
                bif.start = 1'b1;
            end
        end
    endtask

    initial begin
        tbl[0]  = '{4'd1,  3'd2, 32'sh500,         32'sh100,         32'sh7,     16'sd64};
        tbl[1]  = '{4'd1,  3'd0, 32'sh0,           32'sd17,          32'sh12345, -16'sd2};
        tbl[2]  = '{4'd3,  3'd0, 32'sh0,           32'sd256,         32'sh0,     -16'sd16};
        tbl[3]  = '{4'd1,  3'd4, 32'sh4000_0000,   32'shC000_0000,   32'sh0,     16'sd32767};
        tbl[4]  = '{4'd1,  3'd4, 32'shC000_0000,   32'sh4000_0000,   32'sh0,     -16'sd32768};
        tbl[5]  = '{4'd2,  3'd3, 32'sh7FFF0,       32'sh0,           32'sh55,    16'sd32767};
        tbl[6]  = '{4'd2,  3'd3, 32'sh80000,       32'sh0,           32'sh0,     16'sd32767};
        tbl[7]  = '{4'd1,  3'd1, -32'sh80000,      32'sh0,           32'sh0,     -16'sd32768};
        tbl[8]  = '{4'd1,  3'd1, -32'sh80010,      32'sh0,           32'sh0,     -16'sd32768};
        tbl[9]  = '{4'd1,  3'd2, -32'sd1,          32'sh0,           32'sh0,     -16'sd1};
        tbl[10] = '{4'd1,  3'd5, 32'sh500,         32'sh100,         32'sh0,     16'sd0};
        tbl[11] = '{4'd0,  3'd1, 32'sh500,         32'sh100,         32'sh0,     16'sd0};
        tbl[12] = '{4'd15, 3'd7, 32'sh500,         32'sh100,         32'sh0,     16'sd0};
        tbl[13] = '{4'd1,  3'd2, 32'sd15,          32'sh0,           32'sh0,     16'sd0};

        bif.start = 1'b0; bif.step = 4'd0; bif.action = 3'd0; bif.td_target = '0;
        for (int k = 0; k < 5; k++) begin
            qv[k]    = '0;
            exp_d[k] = '0;
        end
        apply_q();

        repeat (3) @(negedge clk);
        check("reset ctrl", bif.ctrl, 0);
        check("reset busy", bif.busy, 0);
        check("reset done", bif.done, 0);
        check("reset err",  bif.err,  0);
        check_deltas("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            for (int k = 0; k < 5; k++) qv[k] = (k == int'(tbl[i].action)) ? tbl[i].qa : tbl[i].qo;
            run_op(tbl[i].step, tbl[i].action, tbl[i].td, 0, $sformatf("tbl%0d", i));
            if (tbl[i].step != 4'd0 && tbl[i].action <= 3'd4)
                check($sformatf("tbl%0d hand", i), out_d(int'(tbl[i].action)), tbl[i].exp);
        end

        // second start while busy must be dropped
        for (int k = 0; k < 5; k++) qv[k] = 32'sh7;
        qv[2] = 32'sh100;
        run_op(4'd1, 3'd2, 32'sh500, 3, "busy_start");
        check("busy_start hand d3", bif.deltab2_3, 64);

        // reset mid-CALC aborts with no update command
        for (int k = 0; k < 5; k++) qv[k] = 32'sh100;
        bif.step = 4'd1; bif.action = 3'd2; bif.td_target = 32'sh500; apply_q();
        bif.start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            check($sformatf("rst ctrl c%0d", c), bif.ctrl, 0);
            check($sformatf("rst done c%0d", c), bif.done, 0);
            if (c >= 5) check($sformatf("rst busy c%0d", c), bif.busy, 0);
            if (c == 5) begin
                for (int k = 0; k < 5; k++) exp_d[k] = '0;
                check_deltas("rst c5");
                rst = 1'b0;
            end
            if (c == 1) bif.start = 1'b0;
            if (c == 4) rst = 1'b1;
        end

        // back-to-back: second request accepted on cycle 7
        for (int k = 0; k < 5; k++) qv[k] = 32'sh40;
        qv[1] = 32'sh100;
        qv[2] = 32'sh100;
        bif.step = 4'd1; bif.action = 3'd2; bif.td_target = 32'sh500; apply_q();
        bif.start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            check($sformatf("b2b busy c%0d", c), bif.busy, (c <= 6 || (c >= 8 && c <= 13)) ? 1 : 0);
            check($sformatf("b2b ctrl c%0d", c), bif.ctrl, (c == 6 || c == 13) ? 1 : 0);
            if (c == 7) check("b2b d3 c7", bif.deltab2_3, 64);
            if (c >= 8) check($sformatf("b2b d3 c%0d", c), bif.deltab2_3, 0);
            if (c == 14) check("b2b d2 c14", bif.deltab2_2, 32);
            if (c == 1 || c == 8) bif.start = 1'b0;
            if (c == 7) begin
                bif.action    = 3'd1;
                bif.td_target = 32'sh300;
                bif.start     = 1'b1;
            end
        end
        for (int k = 0; k < 5; k++) exp_d[k] = '0;
        exp_d[1] = 16'sd32;

        for (int i = 0; i < 60; i++) begin
            logic [3:0]         stp;
            logic [2:0]         act;
            logic signed [31:0] td;
            stp = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            act = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            td  = rnd32();
            for (int k = 0; k < 5; k++) qv[k] = rnd32();
            run_op(stp, act, td, 0, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/deltab2_gen.md
Name: deltab2_gen

Overview:
- Output-layer bias-gradient stage of the DQN training datapath. Sits directly upstream of the output-bias register bank.
- Takes the five Q-value outputs, the TD target and the taken action. Computes the five 16-bit bias deltas serially with one shared subtractor.
- Then issues a one-cycle update command (ctrl = 4'b0001) so the bias bank adds the deltas on the same clock edge.

Parameters:
- LR_SHIFT, 4, learning rate as an arithmetic right shift (lr = 2^-LR_SHIFT); legal range 0..15.
- NUM_OUT, 5, number of output neurons; fixed at 5 for this design.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request one gradient computation; sampled in IDLE only
- step  input  4  training step counter; start ignored while step == 4'b0000
- action  input  3  index of taken action, legal 0..4
- td_target  input  32 signed  TD target (r + gamma*maxQ'), same fixed-point format as bias/Q
- q_1..q_5  input  32 signed each  current Q-value outputs
- ctrl  output  4  4'b0001 for exactly one cycle when deltas are to be applied, else 4'b0000
- deltab2_1..deltab2_5  output  16 signed each  bias deltas, registered
- busy  output  1  high in CALC and APPLY
- done  output  1  one-cycle pulse, coincident with ctrl == 4'b0001
- err  output  1  one-cycle pulse on rejected start (action > 4)

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - ctrl = 0, all deltab2_* = 0, busy = done = err = 0, index = 0.
  - Reset asserted mid-operation aborts at that edge; no ctrl pulse is issued for the aborted request.
- States: IDLE, CALC, APPLY.
- IDLE:
  - Start is accepted when start = 1 and step != 0.
  - On acceptance, latch action, td_target and q_1..q_5 into internal registers.
  - If action <= 4: clear all deltab2_* to 0, set index = 0, go to CALC.
  - If action > 4: stay in IDLE, pulse err the next cycle, deltas unchanged, no ctrl pulse.
  - start with step == 0 is ignored silently.
- CALC:
  - Runs 5 cycles, one per index i = 0..4.
  - When i == latched action: diff = td_target - q_i, computed 33-bit signed (no overflow), then arithmetic right shift by LR_SHIFT (floor, no rounding), then saturate to [-32768, 32767]. Write the result to deltab2_(i+1).
  - Otherwise write deltab2_(i+1) = 0.
  - index increments each cycle; after i = 4, go to APPLY.
- APPLY:
  - One cycle: ctrl = 4'b0001, done = 1.
  - deltab2_* are stable throughout APPLY and remain held afterwards until the next accepted start.
  - Next state is IDLE.
- Latency: start accepted at edge 0, CALC on cycles 1-5, ctrl/done high on cycle 6, back in IDLE on cycle 7. Back-to-back: a new start may be accepted on cycle 7.
- start while busy is ignored (no queuing).
- Input changes after acceptance have no effect, because all operands are latched.
- busy covers exactly cycles 1-6.

Decomposition:
- Shared package dqn_pkg holds:
  - NUM_OUT = 5
  - CTRL_NOP = 4'b0000, CTRL_UPDATE = 4'b0001
  - DELTA_MAX = 16'sh7FFF, DELTA_MIN = -16'sh8000
  - the state enum {IDLE, CALC, APPLY}
- One natural combinational sub-module, dqn_sat_shift: 33-bit signed in, shift amount, 16-bit saturated out. It is reusable for the hidden-layer delta stages.

Test Plan:
- Positive error, LR_SHIFT=4: step=1, action=2, q_3=32'h0000_0100, td_target=32'h0000_0500, start pulse -> deltab2_3=16'sd64, all other deltas 0. ctrl=4'b0001 and done=1 on cycle 6 only; busy high on cycles 1-6.
- Negative error with floor: action=0, q_1=17, td_target=0 -> deltab2_1 = -2 (-17 >>> 4). Then q_1=256, td_target=0 -> -16.
- Saturation:
  - td_target=32'sh4000_0000, q_5=32'shC000_0000, action=4 -> diff = 2^31 (needs the 33-bit path) -> deltab2_5 = 32767.
  - Reversed operands -> deltab2_5 = -32768.
- Rejected and gated starts:
  - action=5, start -> err pulse the next cycle, busy stays 0, no ctrl pulse, previous deltas held.
  - step=0, start -> no response at all.
- Busy and reset:
  - A second start on cycle 3 is ignored; exactly one ctrl pulse occurs, on cycle 6.
  - Separate run: rst asserted on cycle 4 -> next cycle state IDLE, all deltas 0, ctrl never asserted.
- Back-to-back: start on cycle 7 with action=1 -> second ctrl pulse on cycle 13. deltab2_3 from run 1 reads 0 from cycle 8 onward.
